axi_inf_write_slave_core: RTL and testbench

AXI4 write-channel responder: the slave end of the write path driven by the team's AXI write master cores. Accepts one AW burst at a time, takes the W beats under sink backpressure, and forwards each beat to a local write sink as address/data/strobe with a beat-incremented address. Checks burst framing and returns the B response. Used as a memory-model/frame-sink endpoint in the VDMA datapath and its testbenches.

---
 rtl/axi_inf_pkg.sv | 15 +
 rtl/axi_inf_write_slave_core.sv | 186 ++++++++++++++++++
 tb/tb_axi_inf_write_slave_core.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_inf_pkg.sv
// Shared types and encodings for the AXI write-slave core.
package axi_inf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR   = 2'b01;

endpackage

// File: rtl/axi_inf_write_slave_core.sv
// AXI4 write-channel responder: one burst at a time, beats forwarded to a local
// sink with incrementing byte address, framing checked, B response returned.
module axi_inf_write_slave_core
  import axi_inf_pkg::*;
#(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 10,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic                 wr_en,
  output logic [ASIZE-1:0]     wr_addr,
  output logic [DSIZE-1:0]     wr_data,
  output logic [DSIZE/8-1:0]   wr_strb,
  output logic                 wr_last,
  input  logic                 sink_full,
  output logic                 burst_done,
  output logic                 burst_err
);

  localparam int         NBYTES     = DSIZE / 8;
  localparam int         BSHIFT     = $clog2(NBYTES);
  localparam logic [2:0] LEGAL_SIZE = 3'(BSHIFT);

  state_e               state_q, state_d;
  logic                 awready_q, awready_d;
  logic                 bvalid_q, bvalid_d;
  logic [IDSIZE-1:0]    bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [IDSIZE-1:0]    id_q, id_d;
  logic [ASIZE-1:0]     addr_q, addr_d;
  logic [LSIZE-1:0]     len_q, len_d;
  logic [LSIZE-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [ASIZE-1:0]     wr_addr_q, wr_addr_d;
  logic [DSIZE-1:0]     wr_data_q, wr_data_d;
  logic [NBYTES-1:0]    wr_strb_q, wr_strb_d;
  logic                 wr_last_q, wr_last_d;
  logic                 burst_done_q, burst_done_d;
  logic                 burst_err_q, burst_err_d;
  logic                 aw_hs, w_hs, cnt_at_len;

  // DRAIN must swallow stray beats even when the sink is full.
  assign axi_wready = ((state_q == DATA) && !sink_full) || (state_q == DRAIN);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    bid_d        = bid_q;
    bresp_d      = bresp_q;
    wr_en_d      = 1'b0;
    wr_last_d    = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;
    burst_done_d = 1'b0;
    burst_err_d  = 1'b0;
    aw_hs        = axi_awvalid && awready_q;
    w_hs         = axi_wvalid && axi_wready;
    cnt_at_len   = (cnt_q == len_q);

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = axi_awid;
          addr_d  = axi_awaddr;
          len_d   = axi_awlen;
          cnt_d   = '0;
          err_d   = (axi_awburst != BURST_INCR) || (axi_awsize != LEGAL_SIZE);
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // In DATA the error flag can only come from bad AW attributes.
          wr_en_d   = !err_q;
          wr_addr_d = addr_q + (ASIZE'(cnt_q) << BSHIFT);
          wr_data_d = axi_wdata;
          wr_strb_d = axi_wstrb;
          if (axi_wlast || cnt_at_len) begin
            wr_last_d = !err_q;
            state_d   = axi_wlast ? RESP : DRAIN;
            if (axi_wlast != cnt_at_len) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_hs && axi_wlast) state_d = RESP;
      end
      RESP: begin
        if (axi_bready && bvalid_q) begin
          state_d      = IDLE;
          burst_done_d = 1'b1;
          burst_err_d  = (bresp_q == BRESP_SLVERR);
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == RESP) && (state_q != RESP)) begin
      bid_d   = id_q;
      bresp_d = err_d ? BRESP_SLVERR : BRESP_OKAY;
    end

    awready_d = (state_d == IDLE);
    bvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= BRESP_OKAY;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
      wr_last_q    <= 1'b0;
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      bid_q        <= bid_d;
      bresp_q      <= bresp_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strb_q    <= wr_strb_d;
      wr_last_q    <= wr_last_d;
      burst_done_q <= burst_done_d;
      burst_err_q  <= burst_err_d;
    end
  end

  assign axi_awready = awready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bid     = bid_q;
  assign axi_bresp   = bresp_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_strb     = wr_strb_q;
  assign wr_last     = wr_last_q;
  assign burst_done  = burst_done_q;
  assign burst_err   = burst_err_q;

endmodule

// File: tb/tb_axi_inf_write_slave_core.sv
// Directed bench for the AXI write-slave core: framing, backpressure, errors,
// response stall and mid-burst reset.
module tb_axi_inf_write_slave_core;

  logic           clk = 1'b0;
  logic           axi_reset;
  logic [2:0]     axi_awid;
  logic [31:0]    axi_awaddr;
  logic [9:0]     axi_awlen;
  logic [2:0]     axi_awsize;
  logic [1:0]     axi_awburst;
  logic           axi_awvalid;
  logic           axi_awready;
  logic [255:0]   axi_wdata;
  logic [31:0]    axi_wstrb;
  logic           axi_wlast;
  logic           axi_wvalid;
  logic           axi_wready;
  logic [2:0]     axi_bid;
  logic [1:0]     axi_bresp;
  logic           axi_bvalid;
  logic           axi_bready;
  logic           wr_en;
  logic [31:0]    wr_addr;
  logic [255:0]   wr_data;
  logic [31:0]    wr_strb;
  logic           wr_last;
  logic           sink_full;
  logic           burst_done;
  logic           burst_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_strb[$];
  logic        q_last[$];

  always #5 clk = ~clk;

  axi_inf_write_slave_core dut (
    .axi_aclk    (clk),
    .axi_reset   (axi_reset),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_last     (wr_last),
    .sink_full   (sink_full),
    .burst_done  (burst_done),
    .burst_err   (burst_err)
  );

  // Record every sink write seen between clock edges.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data[31:0]);
      q_strb.push_back(wr_strb);
      q_last.push_back(wr_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
  endtask

  // Called at a negedge; returns at the negedge after the AW handshake.
  task automatic do_aw(input logic [2:0] id, input logic [31:0] addr, input logic [9:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len;
    axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
    while (axi_awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("aw_ready_seen", axi_awready, 1);
    @(negedge clk);
    axi_awvalid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the W handshake.
  task automatic w_beat(input logic [31:0] d, input logic [31:0] s, input logic l);
    int n = 0;
    axi_wvalid = 1'b1; axi_wdata = {8{d}}; axi_wstrb = s; axi_wlast = l;
    #1;
    while (axi_wready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    check("w_ready_seen", axi_wready, 1);
    @(negedge clk);
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
  endtask

  task automatic b_resp(input logic [2:0] id, input logic [1:0] resp, input int stall);
    int n = 0;
    while (axi_bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("bvalid", axi_bvalid, 1);
    check("bid", axi_bid, id);
    check("bresp", axi_bresp, resp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_bvalid", axi_bvalid, 1);
      check("stall_bid", axi_bid, id);
      check("stall_bresp", axi_bresp, resp);
      check("stall_awready", axi_awready, 0);
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check("burst_done", burst_done, 1);
    check("burst_err", burst_err, (resp == 2'b10) ? 1 : 0);
    check("bvalid_drop", axi_bvalid, 0);
    check("awready_back", axi_awready, 1);
    @(negedge clk);
    check("burst_done_pulse", burst_done, 0);
    check("burst_err_pulse", burst_err, 0);
  endtask

  initial begin
    axi_reset = 1'b1; axi_awid = '0; axi_awaddr = '0; axi_awlen = '0;
    axi_awsize = 3'b101; axi_awburst = 2'b01; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; sink_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", axi_awready, 0);
    check("rst_wready", axi_wready, 0);
    check("rst_bvalid", axi_bvalid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bresp", axi_bresp, 0);
    check("rst_burst_done", burst_done, 0);
    axi_reset = 1'b0;
    @(negedge clk);
    check("rel_awready", axi_awready, 1);

    // Nominal 4-beat burst.
    clear_q();
    do_aw(3'd5, 32'h1000, 10'd3, 3'b101, 2'b01);
    check("nom_awready_low", axi_awready, 0);
    check("nom_wready_first", axi_wready, 1);
    w_beat(32'hA000_0000, 32'hFFFF_FFFF, 1'b0);
    check("nom_wr_en_lat", wr_en, 1);
    check("nom_wr_addr0", wr_addr, 32'h1000);
    check("nom_wr_last0", wr_last, 0);
    check("nom_wr_strb0", wr_strb, 32'hFFFF_FFFF);
    for (int i = 1; i < 4; i++) w_beat(32'hA000_0000 + i, 32'hFFFF_FFFF, i == 3);
    b_resp(3'd5, 2'b00, 0);
    check("nom_count", q_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("nom_addr", q_addr[i], 32'h1000 + 32 * i);
      check("nom_data", q_data[i], 32'hA000_0000 + i);
      check("nom_last", q_last[i], (i == 3) ? 1 : 0);
    end

    // Backpressure mid-burst.
    clear_q();
    do_aw(3'd1, 32'h2000, 10'd7, 3'b101, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hB000_0000 + i, 32'hFFFF_FFFF, 1'b0);
    axi_wvalid = 1'b1; axi_wdata = {8{32'hB000_0004}};
    for (int i = 0; i < 3; i++) begin
      sink_full = 1'b1;
      #1;
      check("bp_wready_low", axi_wready, 0);
      @(negedge clk);
    end
    sink_full = 1'b0;
    #1;
    check("bp_wready_high", axi_wready, 1);
    for (int i = 4; i < 8; i++) w_beat(32'hB000_0000 + i, 32'hFFFF_FFFF, i == 7);
    b_resp(3'd1, 2'b00, 0);
    check("bp_count", q_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("bp_addr", q_addr[i], 32'h2000 + 32 * i);
      check("bp_data", q_data[i], 32'hB000_0000 + i);
    end

    // Early wlast.
    clear_q();
    do_aw(3'd2, 32'h3000, 10'd3, 3'b101, 2'b01);
    w_beat(32'hC000_0000, 32'h0000_FFFF, 1'b0);
    w_beat(32'hC000_0001, 32'hFFFF_0000, 1'b1);
    b_resp(3'd2, 2'b10, 0);
    check("early_count", q_addr.size(), 2);
    check("early_last0", q_last[0], 0);
    check("early_last1", q_last[1], 1);
    check("early_addr1", q_addr[1], 32'h3020);
    check("early_strb1", q_strb[1], 32'hFFFF_0000);

    // Missing wlast: overrun beats drained.
    clear_q();
    do_aw(3'd3, 32'h4000, 10'd1, 3'b101, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hD000_0000 + i, 32'hFFFF_FFFF, i == 3);
    b_resp(3'd3, 2'b10, 0);
    check("miss_count", q_addr.size(), 2);
    check("miss_addr1", q_addr[1], 32'h4020);
    check("miss_last1", q_last[1], 1);

    // Bad burst type, then bad size, then a legal burst with a stalled response.
    clear_q();
    do_aw(3'd4, 32'h5000, 10'd2, 3'b101, 2'b00);
    for (int i = 0; i < 3; i++) w_beat(32'hE000_0000 + i, 32'hFFFF_FFFF, i == 2);
    b_resp(3'd4, 2'b10, 0);
    check("badburst_count", q_addr.size(), 0);
    do_aw(3'd4, 32'h5000, 10'd0, 3'b011, 2'b01);
    w_beat(32'hE100_0000, 32'hFFFF_FFFF, 1'b1);
    b_resp(3'd4, 2'b10, 0);
    check("badsize_count", q_addr.size(), 0);
    do_aw(3'd6, 32'h5000, 10'd0, 3'b101, 2'b01);
    w_beat(32'hE200_0000, 32'hFFFF_FFFF, 1'b1);
    b_resp(3'd6, 2'b00, 5);
    check("legal_count", q_addr.size(), 1);
    check("legal_addr", q_addr[0], 32'h5000);
    check("legal_last", q_last[0], 1);

    // Reset during DATA.
    do_aw(3'd2, 32'h6000, 10'd3, 3'b101, 2'b01);
    w_beat(32'hF000_0000, 32'hFFFF_FFFF, 1'b0);
    check("rd_wr_en", wr_en, 1);
    check("rd_wr_addr", wr_addr, 32'h6000);
    axi_wvalid = 1'b1;
    axi_reset = 1'b1;
    @(negedge clk);
    #1;
    check("rd_awready", axi_awready, 0);
    check("rd_wready", axi_wready, 0);
    check("rd_bvalid", axi_bvalid, 0);
    check("rd_wr_en0", wr_en, 0);
    check("rd_wr_addr0", wr_addr, 0);
    check("rd_wr_data0", wr_data[63:0], 0);
    check("rd_wr_last", wr_last, 0);
    check("rd_bid", axi_bid, 0);
    axi_wvalid = 1'b0;
    axi_reset = 1'b0;
    @(negedge clk);
    check("rd_awready_rel", axi_awready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
